pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the five-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Consumes ID-stage decode fields, the EX-stage redirect and the data-memory busy handshake.
- Drives per-stage stall/flush, the PC-load strobe and EX operand forwarding selects.
- Keeps its own shadow scoreboard of destination registers in flight through EX, MEM and WB.

Parameters:
- FWD_EN, 1: 1 = forward from MEM/WB into EX; 0 = no forwarding, stall on every RAW against EX or MEM.
- CNT_W, 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5 each  source register addresses from the decoder.
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads the source.
- id_rd  in  5  destination register.
- id_r_wren  in  1  instruction writes a register.
- id_is_load  in  1  instruction is a load.
- ex_redirect  in  1  branch taken or JAL/JALR resolved in EX this cycle.
- dmem_busy  in  1  MEM-stage access not complete; hold pipeline.
- stall_if, stall_id  out  1 each  hold PC / IF-ID register.
- freeze_all  out  1  hold every pipeline register (memory wait).
- flush_id, flush_ex  out  1 each  load a bubble into IF/ID, ID/EX.
- pc_load  out  1  PC takes the EX redirect target.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM ALU result, 10 WB write data.
- stall_cnt  out  CNT_W  count of cycles with any stall or freeze asserted.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All outputs 0.
  - Shadow EX/MEM/WB entries invalid; FSM enters RUN; stall_cnt = 0.
- Shadow entry fields: {valid, rd, wren, is_load, rs1, rs2, use1, use2}. A valid entry with rd=0 is treated as wren=0.
- Advance, when the pipeline is not frozen:
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields. ID fields are captured as invalid when flush_ex or the load-use bubble applies.
- FSM states: RUN, MEM_WAIT, REDIRECT.
  - RUN, dmem_busy=1: enter MEM_WAIT. freeze_all=1 combinationally in the same cycle; no shadow advance.
  - MEM_WAIT: freeze_all=1 while dmem_busy. On dmem_busy=0, return to RUN and advance that cycle.
  - RUN, ex_redirect=1 and dmem_busy=0: pc_load=1, flush_id=1, flush_ex=1 in the same cycle; enter REDIRECT.
  - REDIRECT: lasts 1 cycle with no extra outputs; the fetched target enters IF; return to RUN.
    - dmem_busy in REDIRECT goes to MEM_WAIT.
    - ex_redirect is ignored in REDIRECT, because EX holds a bubble.
- Load-use hazard (RUN, no redirect):
  - Condition: EX shadow valid, is_load, wren, and id_valid, where rd == id_rs1 with use1, or rd == id_rs2 with use2.
  - Response: stall_if=1, stall_id=1, flush_ex=1 for exactly one cycle.
- FWD_EN=0 RAW: the same match against the EX or MEM shadow (any wren) gives the same stall/bubble each cycle until cleared. fwd_a/fwd_b stay 00.
- Forwarding (FWD_EN=1), combinational from the EX shadow:
  - fwd_a=01 if MEM valid, wren, not is_load, MEM.rd == EX.rs1 and EX.use1.
  - Else fwd_a=10 if WB valid, wren, WB.rd == EX.rs1.
  - Else 00. fwd_b is identical using rs2/use2.
  - MEM has priority over WB. Register 0 is never forwarded.
- Priority for simultaneous events: dmem_busy > ex_redirect > load-use > normal.
  - A redirect coincident with busy is not lost: EX is frozen, so ex_redirect re-presents when busy drops.
- stall_cnt increments on any cycle with stall_id | freeze_all and saturates at all-ones.
- Reset mid-MEM_WAIT or mid-REDIRECT returns to RUN with shadows cleared, in the same edge.

Decomposition:
- Shared package/header: FSM state encodings (RUN=2'd0, MEM_WAIT=2'd1, REDIRECT=2'd2) and forwarding select codes (FWD_REG, FWD_MEM, FWD_WB), alongside the existing opcode defines.
- Sub-module: hazard_scoreboard.
  - Holds the three shadow entries plus their advance/bubble logic.
  - Exports the match vectors.
  - The FSM and output priority stay in the top level.

Test Plan:
- lw x5 in EX, ID add x6,x5,x1 (use1) -> one cycle stall_if=stall_id=flush_ex=1, then fwd_a=10 when add reaches EX; stall_cnt=1.
- add x3 in MEM and add x3 in WB, EX reads x3 as rs2 -> fwd_b=01 (MEM priority); same with rd=x0 -> fwd_b=00.
- ex_redirect=1 in RUN -> same cycle pc_load=flush_id=flush_ex=1; next cycle state REDIRECT with all outputs 0; then RUN.
- dmem_busy held 3 cycles coincident with ex_redirect -> freeze_all=1 for 3 cycles, no pc_load; pc_load=1 on the cycle busy drops; stall_cnt +=3.
- FWD_EN=0, ID reads x7 written by add in EX -> stall 2 cycles (EX, then MEM) and release when producer reaches WB; fwd always 00.
- rst_n=0 during MEM_WAIT -> next cycle all outputs 0, stall_cnt=0, no forwarding from stale shadows.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encodings, forwarding
// select codes and the shadow-entry field groups.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Destination side of a shadow entry
    typedef struct packed {
        logic [4:0] rd;
        logic       wren;
        logic       is_load;
    } dest_t;

    // Source side of a shadow entry (only needed while the entry sits in EX)
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } src_t;

    // An entry really produces a register only if valid, writing, and rd != x0
    function automatic logic writes_reg(input logic vld, input dest_t d);
        return vld && d.wren && (d.rd != 5'd0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// Shadow copies of the EX, MEM and WB destination registers, advanced in
// lockstep with the real pipeline, and the register-match vectors the hazard
// controller needs for stalling and forwarding.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic       bubble,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_r_wren,
    input  logic       id_is_load,
    output logic       ld_use_hit,
    output logic       raw_ex_hit,
    output logic       raw_mem_hit,
    output logic       mem_hit_rs1,
    output logic       mem_hit_rs2,
    output logic       wb_hit_rs1,
    output logic       wb_hit_rs2
);

    logic       vld_p0, vld_p1, vld_p2;
    dest_t      ex_dst_p0, mem_dst_p1;
    src_t       ex_src_p0;
    logic [4:0] wb_rd_p2;
    logic       wb_wren_p2;
    logic       ex_wr, mem_wr, wb_wr;

    // Valid bits: cleared by reset, a flushed/bubbled ID enters EX as invalid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (advance) begin
            vld_p0 <= id_valid && !bubble;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Entry payloads move with the valid bits; their content is don't-care when invalid
    always_ff @(posedge clk) begin
        if (advance) begin
            ex_dst_p0  <= '{rd: id_rd, wren: id_r_wren, is_load: id_is_load};
            ex_src_p0  <= '{rs1: id_rs1, rs2: id_rs2, use1: id_use_rs1, use2: id_use_rs2};
            mem_dst_p1 <= ex_dst_p0;
            wb_rd_p2   <= mem_dst_p1.rd;
            wb_wren_p2 <= mem_dst_p1.wren;
        end
    end

    // Register-match vectors against the instruction in ID and the one in EX
    always_comb begin
        ex_wr  = writes_reg(vld_p0, ex_dst_p0);
        mem_wr = writes_reg(vld_p1, mem_dst_p1);
        wb_wr  = vld_p2 && wb_wren_p2 && (wb_rd_p2 != 5'd0);

        raw_ex_hit  = ex_wr && id_valid &&
                      ((ex_dst_p0.rd == id_rs1 && id_use_rs1) ||
                       (ex_dst_p0.rd == id_rs2 && id_use_rs2));
        raw_mem_hit = mem_wr && id_valid &&
                      ((mem_dst_p1.rd == id_rs1 && id_use_rs1) ||
                       (mem_dst_p1.rd == id_rs2 && id_use_rs2));
        ld_use_hit  = raw_ex_hit && ex_dst_p0.is_load;

        // A load in MEM has no ALU result to forward yet
        mem_hit_rs1 = mem_wr && !mem_dst_p1.is_load &&
                      mem_dst_p1.rd == ex_src_p0.rs1 && ex_src_p0.use1;
        mem_hit_rs2 = mem_wr && !mem_dst_p1.is_load &&
                      mem_dst_p1.rd == ex_src_p0.rs2 && ex_src_p0.use2;
        wb_hit_rs1  = wb_wr && wb_rd_p2 == ex_src_p0.rs1;
        wb_hit_rs2  = wb_wr && wb_rd_p2 == ex_src_p0.rs2;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a five-stage RV32I pipeline: memory
// wait freeze, EX redirect flush, load-use / RAW stalls and EX forwarding.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_r_wren,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             freeze_all,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             pc_load,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t state, state_nxt;
    logic   ld_use_hit, raw_ex_hit, raw_mem_hit;
    logic   mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;
    logic   data_hazard;

    hazard_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (!freeze_all),
        .bubble     (flush_ex),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_r_wren  (id_r_wren),
        .id_is_load (id_is_load),
        .ld_use_hit (ld_use_hit),
        .raw_ex_hit (raw_ex_hit),
        .raw_mem_hit(raw_mem_hit),
        .mem_hit_rs1(mem_hit_rs1),
        .mem_hit_rs2(mem_hit_rs2),
        .wb_hit_rs1 (wb_hit_rs1),
        .wb_hit_rs2 (wb_hit_rs2)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // Next state: memory wait dominates; a redirect is only taken outside REDIRECT
    always_comb begin
        state_nxt = ST_RUN;
        if (dmem_busy)
            state_nxt = ST_MEM_WAIT;
        else if (state != ST_REDIRECT && ex_redirect)
            state_nxt = ST_REDIRECT;
    end

    // Control outputs in priority order busy > redirect > data hazard.
    // MEM_WAIT with busy released behaves exactly like RUN for that cycle.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        freeze_all  = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        pc_load     = 1'b0;
        data_hazard = (FWD_EN != 0) ? ld_use_hit : (raw_ex_hit || raw_mem_hit);
        if (dmem_busy) begin
            freeze_all = 1'b1;
        end else if (state != ST_REDIRECT) begin
            if (ex_redirect) begin
                pc_load  = 1'b1;
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (data_hazard) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    // Forwarding selects for the EX operands; MEM result beats WB data
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (FWD_EN != 0) begin
            if (mem_hit_rs1)     fwd_a = FWD_MEM;
            else if (wb_hit_rs1) fwd_a = FWD_WB;
            if (mem_hit_rs2)     fwd_b = FWD_MEM;
            else if (wb_hit_rs2) fwd_b = FWD_WB;
        end
    end

    // Saturating count of cycles spent stalled or frozen
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if ((stall_id || freeze_all) && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a forwarding instance (CNT_W=32) and a
// non-forwarding instance with a 2-bit counter share the same input stimulus.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs1, id_use_rs2, id_r_wren, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect, dmem_busy;

    logic        stall_if, stall_id, freeze_all, flush_id, flush_ex, pc_load;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt;
    logic        stall_if0, stall_id0, freeze_all0, flush_id0, flush_ex0, pc_load0;
    logic [1:0]  fwd_a0, fwd_b0;
    logic [1:0]  stall_cnt0;

    logic [5:0] ctl, ctl0;
    assign ctl  = {stall_if, stall_id, freeze_all, flush_id, flush_ex, pc_load};
    assign ctl0 = {stall_if0, stall_id0, freeze_all0, flush_id0, flush_ex0, pc_load0};

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b110010;
    localparam logic [5:0] C_FRZ   = 6'b001000;
    localparam logic [5:0] C_REDIR = 6'b000111;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FWD_EN(1), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_r_wren(id_r_wren), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .dmem_busy(dmem_busy), .stall_if(stall_if), .stall_id(stall_id),
        .freeze_all(freeze_all), .flush_id(flush_id), .flush_ex(flush_ex),
        .pc_load(pc_load), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_r_wren(id_r_wren), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .dmem_busy(dmem_busy), .stall_if(stall_if0), .stall_id(stall_id0),
        .freeze_all(freeze_all0), .flush_id(flush_id0), .flush_ex(flush_ex0),
        .pc_load(pc_load0), .fwd_a(fwd_a0), .fwd_b(fwd_b0), .stall_cnt(stall_cnt0)
    );

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in ID; the short settle lets combinational outputs resolve
    task automatic set_id(input logic v, input logic [4:0] rd, input logic w, input logic ld,
                          input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        id_valid = v;  id_rd = rd; id_r_wren = w; id_is_load = ld;
        id_rs1 = r1;   id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
        #1;
    endtask

    task automatic idle_id();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ex_redirect = 1'b0; dmem_busy = 1'b0;
        idle_id();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if ({ctl, fwd_a, fwd_b} !== 10'd0) begin
            tests_failed++; $display("FAIL reset_outputs: got %b expected 0", {ctl, fwd_a, fwd_b});
        end
        tests_run++;
        if (stall_cnt !== 32'd0) begin
            tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);   // lw x5, 0(x1)
        tests_run++;
        if (ctl !== C_IDLE) begin
            tests_failed++; $display("FAIL lu_no_hazard: got %b expected %b", ctl, C_IDLE);
        end
        step();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1);   // add x6, x5, x1
        tests_run++;
        if (ctl !== C_STALL) begin
            tests_failed++; $display("FAIL lu_stall: got %b expected %b", ctl, C_STALL);
        end
        step();
        #1;
        tests_run++;
        if (ctl !== C_IDLE) begin
            tests_failed++; $display("FAIL lu_one_cycle: got %b expected %b", ctl, C_IDLE);
        end
        tests_run++;
        if (stall_cnt !== 32'd1) begin
            tests_failed++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt);
        end
        step();
        idle_id();
        tests_run++;
        if ({fwd_a, fwd_b} !== 4'b1000) begin
            tests_failed++; $display("FAIL lu_fwd_wb: got %b expected 1000", {fwd_a, fwd_b});
        end
    endtask

    task automatic test_fwd_priority();
        do_reset();
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);   // add x3
        step();
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);   // add x3
        step();
        set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);   // reads x3 as rs2
        tests_run++;
        if (ctl !== C_IDLE) begin
            tests_failed++; $display("FAIL fwd_no_stall: got %b expected %b", ctl, C_IDLE);
        end
        step();
        idle_id();
        tests_run++;
        if ({fwd_a, fwd_b} !== 4'b0001) begin
            tests_failed++; $display("FAIL fwd_mem_prio: got %b expected 0001", {fwd_a, fwd_b});
        end
        // producer only in WB
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        idle_id();
        step();
        set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        step();
        idle_id();
        tests_run++;
        if ({fwd_a, fwd_b} !== 4'b0010) begin
            tests_failed++; $display("FAIL fwd_wb_only: got %b expected 0010", {fwd_a, fwd_b});
        end
        // x0 producers are never forwarded
        set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        step();
        idle_id();
        tests_run++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            tests_failed++; $display("FAIL fwd_x0: got %b expected 0000", {fwd_a, fwd_b});
        end
    endtask

    task automatic test_redirect();
        do_reset();
        ex_redirect = 1'b1;
        #1;
        tests_run++;
        if (ctl !== C_REDIR) begin
            tests_failed++; $display("FAIL redir_run: got %b expected %b", ctl, C_REDIR);
        end
        step();
        tests_run++;
        if (ctl !== C_IDLE) begin
            tests_failed++; $display("FAIL redir_state_quiet: got %b expected %b", ctl, C_IDLE);
        end
        step();
        tests_run++;
        if (ctl !== C_REDIR) begin
            tests_failed++; $display("FAIL redir_back_to_run: got %b expected %b", ctl, C_REDIR);
        end
        ex_redirect = 1'b0;
        step();
        step();
        tests_run++;
        if (stall_cnt !== 32'd0) begin
            tests_failed++; $display("FAIL redir_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_busy_redirect();
        do_reset();
        dmem_busy = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (ctl !== C_FRZ) begin
                tests_failed++; $display("FAIL busy_freeze_%0d: got %b expected %b", i, ctl, C_FRZ);
            end
            step();
        end
        dmem_busy = 1'b0;
        #1;
        tests_run++;
        if (ctl !== C_REDIR) begin
            tests_failed++; $display("FAIL busy_redir_release: got %b expected %b", ctl, C_REDIR);
        end
        tests_run++;
        if (stall_cnt !== 32'd3) begin
            tests_failed++; $display("FAIL busy_cnt: got %0d expected 3", stall_cnt);
        end
        step();
        ex_redirect = 1'b0;
        step();
    endtask

    task automatic test_freeze_holds();
        do_reset();
        set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);   // lw x5
        step();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);   // add x6, x5
        dmem_busy = 1'b1;
        #1;
        tests_run++;
        if (ctl !== C_FRZ) begin
            tests_failed++; $display("FAIL frz_busy_prio: got %b expected %b", ctl, C_FRZ);
        end
        step();
        step();
        dmem_busy = 1'b0;
        #1;
        tests_run++;
        if (ctl !== C_STALL) begin
            tests_failed++; $display("FAIL frz_ex_held: got %b expected %b", ctl, C_STALL);
        end
        step();
        idle_id();
        tests_run++;
        if (stall_cnt !== 32'd3) begin
            tests_failed++; $display("FAIL frz_cnt: got %0d expected 3", stall_cnt);
        end
    endtask

    task automatic test_no_forwarding();
        do_reset();
        set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);   // add x7
        step();
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);   // add x8, x7
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (ctl0 !== ((i < 2) ? C_STALL : C_IDLE)) begin
                tests_failed++;
                $display("FAIL nofwd_stall_%0d: got %b expected %b", i, ctl0, (i < 2) ? C_STALL : C_IDLE);
            end
            tests_run++;
            if ({fwd_a0, fwd_b0} !== 4'b0000) begin
                tests_failed++; $display("FAIL nofwd_sel_%0d: got %b expected 0000", i, {fwd_a0, fwd_b0});
            end
            step();
            #1;
        end
        idle_id();
        tests_run++;
        if (stall_cnt0 !== 2'd2) begin
            tests_failed++; $display("FAIL nofwd_cnt: got %0d expected 2", stall_cnt0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        dmem_busy = 1'b1;
        for (int i = 0; i < 5; i++) step();
        dmem_busy = 1'b0;
        #1;
        tests_run++;
        if (stall_cnt0 !== 2'd3) begin
            tests_failed++; $display("FAIL sat_cnt_narrow: got %0d expected 3", stall_cnt0);
        end
        tests_run++;
        if (stall_cnt !== 32'd5) begin
            tests_failed++; $display("FAIL sat_cnt_wide: got %0d expected 5", stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        idle_id();
        dmem_busy = 1'b1;
        step();
        step();
        rst_n = 1'b0; dmem_busy = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        tests_run++;
        if ({ctl, fwd_a, fwd_b} !== 10'd0) begin
            tests_failed++; $display("FAIL rstwait_outputs: got %b expected 0", {ctl, fwd_a, fwd_b});
        end
        tests_run++;
        if (stall_cnt !== 32'd0) begin
            tests_failed++; $display("FAIL rstwait_cnt: got %0d expected 0", stall_cnt);
        end
        set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1);
        step();
        idle_id();
        tests_run++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            tests_failed++; $display("FAIL rstwait_stale_fwd: got %b expected 0000", {fwd_a, fwd_b});
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_redirect();
        test_busy_redirect();
        test_freeze_holds();
        test_no_forwarding();
        test_saturation();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
